mult_pair_sequencer: RTL
========================

// Module: mult_pair_sequencer
// PURPOSE
//  Upstream feeder and downstream collector for the dual-multiplier block (double_multipler).
//  Buffers IEEE754 single-precision operand pairs from a valid/ready stream.
//  Issues them two at a time using the multiplier's ready/op protocol.
//  Captures the two results during the done window and returns them, tagged, on an output valid/ready stream.
// PARAMETERS
//  IN_DEPTH     4    operand-pair FIFO entries (power of 2, >=2)
//  OUT_DEPTH    4    result FIFO entries (power of 2, >=2)
//  TIMEOUT_CYC  256  cycles in WAIT before err_timeout is raised
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  in_valid     in   1   operand pair valid
//  in_ready     out  1   pair accepted when in_valid&&in_ready
//  in_op1       in   32  operand 1 (IEEE754 single)
//  in_op2       in   32  operand 2
//  flush        in   1   level; allows issue of a lone pending pair
//  mul_ready    out  1   start pulse to multiplier (registered)
//  mul_op1      out  32  multiplier operand 1 (registered)
//  mul_op2      out  32  multiplier operand 2 (registered)
//  mul_res      in   32  multiplier result
//  mul_done     in   1   multiplier done; high 2 cycles: res A, then res B
//  out_valid    out  1   result FIFO non-empty
//  out_ready    in   1   consumer pops when out_valid&&out_ready
//  out_res      out  32  result at FIFO head
//  out_tag      out  1   0 = first pair of transaction, 1 = second
//  busy         out  1   FSM not in IDLE
//  err_timeout  out  1   sticky; cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; both FIFOs empty; FSM in IDLE; timeout counter 0.
//   in_ready rises the first cycle after rst deasserts.
//  Input FIFO:
//   in_ready = (in_count < IN_DEPTH).
//   Simultaneous push and FSM pop is legal at any non-full count.
//  FSM states: IDLE, ISSUE_B, WAIT, CAP_B.
//  IDLE: issue condition is
//   (in_count>=2 || (in_count==1 && flush)) && out_free>=2 && !mul_done.
//   When it holds, pop pair A and set mul_ready<=1, mul_op<=A.
//   Set pad<=(in_count==1). Go to ISSUE_B.
//  ISSUE_B:
//   mul_ready<=0.
//   If !pad: pop pair B and set mul_op<=B. If pad: mul_op<=32'h0.
//   Go to WAIT. Net effect: pair B is presented exactly one cycle after the mul_ready pulse.
//  WAIT: on first cycle with mul_done=1, push {tag0, mul_res}. Go to CAP_B.
//   The timeout counter increments each WAIT cycle and saturates.
//   At TIMEOUT_CYC, set err_timeout<=1. The FSM keeps waiting; there is no abort.
//  CAP_B: push {tag1, mul_res} unless pad. Go to IDLE; the counter clears.
//   The next issue may occur the cycle after CAP_B.
//  Latency from issue to tag0 result in the FIFO = multiplier latency + 1.
//  Result FIFO slots are reserved by the out_free>=2 check. It never overflows; do not drop writes.
//  mul_done outside WAIT/CAP_B is ignored (e.g. a late done after reset).
//  Reset mid-transaction: in-flight pair and results are discarded; no partial output.
//  flush deasserted with one pair pending: the pair is held indefinitely; no issue.
//  Results are FIFO-ordered: tag0 always precedes the tag1 of the same transaction.
// STRUCTURE
//  mult_seq_defs.vh: state encodings, FP_W=32, TAG_W=1.
//  Sub-module sync_fifo #(WIDTH, DEPTH): count/full/empty outputs, async rst.
//   Instantiated twice: input FIFO (64 bits) and result FIFO (33 bits).
//  FSM and timeout counter live in this module.
// TESTING (stub multiplier with the done-for-2-cycles protocol, variable latency)
//  1. Pairs (3F800000,40000000),(40400000,40400000) -> single 1-cycle mul_ready, ops A then B next cycle;
//     out: 40000000/tag0, then 41100000/tag1.
//  2. One pair, flush=0 for 50 cycles -> no mul_ready; then flush=1 -> single tag0 result only.
//     mul_op2=0 on the pad cycle.
//  3. out_ready=0, OUT_DEPTH=4, 6 pairs -> 2 transactions complete, third stalls.
//     Pop 2 results -> third issues.
//  4. Stub never asserts done, TIMEOUT_CYC=16 -> err_timeout=1 on WAIT cycle 16; stays 1; busy stays 1.
//  5. rst in WAIT, stub later asserts done -> all outputs 0, out_valid stays 0, no spurious issue.
//  6. 5 pairs pushed with issue blocked -> in_ready=0 after 4 accepted; 5th accepted the cycle after a pop.

Source files
------------

// File: rtl/mult_pair_sequencer_pkg.sv
// Shared widths, FSM state encoding and entry layouts for the multiplier pair sequencer.
package mult_pair_sequencer_pkg;

  localparam int FP_W   = 32;
  localparam int TAG_W  = 1;
  localparam int PAIR_W = 2 * FP_W;
  localparam int RES_W  = TAG_W + FP_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE_B = 2'd1,
    S_WAIT    = 2'd2,
    S_CAP_B   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [FP_W-1:0] op1;
    logic [FP_W-1:0] op2;
  } pair_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [FP_W-1:0]  res;
  } res_entry_t;

endpackage

// File: rtl/mult_pair_sequencer_sync_fifo.sv
// Single-clock FIFO with occupancy count; simultaneous push and pop allowed when not full.
module mult_pair_sequencer_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mult_pair_sequencer.sv
// Feeds operand pairs two at a time to the dual multiplier and collects its tagged results.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | waiting for pairs and two free result slots; issues pair A
//   S_ISSUE_B | presents pair B (or zeros when padding a lone pair)
//   S_WAIT    | waiting for mul_done; captures result A; timeout runs here
//   S_CAP_B   | captures result B unless padded, then back to idle
module mult_pair_sequencer
  import mult_pair_sequencer_pkg::*;
#(
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_op1,
  input  logic [FP_W-1:0] in_op2,
  input  logic            flush,
  output logic            mul_ready,
  output logic [FP_W-1:0] mul_op1,
  output logic [FP_W-1:0] mul_op2,
  input  logic [FP_W-1:0] mul_res,
  input  logic            mul_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_res,
  output logic            out_tag,
  output logic            busy,
  output logic            err_timeout
);

  localparam int IN_CW  = $clog2(IN_DEPTH + 1);
  localparam int OUT_CW = $clog2(OUT_DEPTH + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  seq_state_t        state;
  logic              pad;
  logic              rst_done;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              in_push;
  logic              in_pop;
  logic [PAIR_W-1:0] in_dout;
  logic [IN_CW-1:0]  in_count;
  logic              in_full;
  logic              in_empty;
  pair_t             in_head;

  logic              res_push;
  logic              res_pop;
  res_entry_t        res_din;
  logic [RES_W-1:0]  res_dout;
  logic [OUT_CW-1:0] res_count;
  logic              res_full;
  logic              res_empty;
  res_entry_t        res_head;
  logic [OUT_CW-1:0] out_free;
  logic              issue_ok;

  // in_ready is held low until the first edge after reset release.
  assign in_ready = rst_done && !in_full;
  assign in_push  = in_valid && in_ready;
  assign in_head  = pair_t'(in_dout);

  assign out_free = OUT_CW'(OUT_DEPTH) - res_count;
  assign issue_ok = ((in_count >= IN_CW'(2)) || ((in_count == IN_CW'(1)) && flush))
                    && (out_free >= OUT_CW'(2)) && !mul_done;

  assign in_pop = !in_empty &&
                  (((state == S_IDLE) && issue_ok) || ((state == S_ISSUE_B) && !pad));

  // Slots were reserved at issue, so the full guard never blocks a real result.
  assign res_push = !res_full &&
                    (((state == S_WAIT) && mul_done) || ((state == S_CAP_B) && !pad));

  always_comb begin
    res_din     = '0;
    res_din.tag = TAG_W'(state == S_CAP_B);
    res_din.res = mul_res;
  end

  assign res_pop   = out_valid && out_ready;
  assign res_head  = res_entry_t'(res_dout);
  assign out_valid = !res_empty;
  assign out_res   = res_empty ? '0 : res_head.res;
  assign out_tag   = res_empty ? 1'b0 : res_head.tag[0];
  assign busy      = (state != S_IDLE);

  mult_pair_sequencer_sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .din   ({in_op1, in_op2}),
    .pop   (in_pop),
    .dout  (in_dout),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  mult_pair_sequencer_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .din   (res_din),
    .pop   (res_pop),
    .dout  (res_dout),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pad         <= 1'b0;
      rst_done    <= 1'b0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
      mul_ready   <= 1'b0;
      mul_op1     <= '0;
      mul_op2     <= '0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        S_IDLE: begin
          if (issue_ok) begin
            mul_ready <= 1'b1;
            mul_op1   <= in_head.op1;
            mul_op2   <= in_head.op2;
            pad       <= (in_count == IN_CW'(1));
            state     <= S_ISSUE_B;
          end
        end
        S_ISSUE_B: begin
          mul_ready <= 1'b0;
          if (pad) begin
            mul_op1 <= '0;
            mul_op2 <= '0;
          end else begin
            mul_op1 <= in_head.op1;
            mul_op2 <= in_head.op2;
          end
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            state <= S_CAP_B;
          end else begin
            if (tmo_cnt != TMO_MAX)  tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt == TMO_LAST) err_timeout <= 1'b1;
          end
        end
        S_CAP_B: begin
          tmo_cnt <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
